// File: rtl/riscv_multicycle_control_if.sv
// Control bus between the multi-cycle sequencer and the shared datapath/memory.
// The sequencer is the master; the datapath and memory side is the slave.
interface riscv_multicycle_control_if;
   logic [6:0] Opcode;
   logic       Zero;
   logic       Mem_ready;
   logic       PC_Write;
   logic       PC_src;
   logic       IR_Write;
   logic       I_or_D;
   logic       Mem_Read;
   logic       Mem_Write;
   logic       Mem_to_Reg;
   logic       Reg_Write;
   logic       ALU_src;
   logic       Branch;
   logic [1:0] ALU_op;
   logic [2:0] State;
   logic       Error;

   modport master (
      input  Opcode, Zero, Mem_ready,
      output PC_Write, PC_src, IR_Write, I_or_D, Mem_Read, Mem_Write,
             Mem_to_Reg, Reg_Write, ALU_src, Branch, ALU_op, State, Error
   );

   modport slave (
      output Opcode, Zero, Mem_ready,
      input  PC_Write, PC_src, IR_Write, I_or_D, Mem_Read, Mem_Write,
             Mem_to_Reg, Reg_Write, ALU_src, Branch, ALU_op, State, Error
   );
endinterface

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared memory,
// with a memory-wait timeout and illegal-opcode detection into a sticky TRAP.
module riscv_multicycle_control #(
   parameter int TIMEOUT = 15
) (
   input logic                           clk,
   input logic                           reset,
   riscv_multicycle_control_if.master    bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [3:0] CNT_LAST  = 4'(TIMEOUT - 1);

   state_t     state, state_next;
   logic [6:0] opcode_q;
   logic [3:0] wait_cnt;
   logic       error_q;

   logic       pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, reg_write, alu_src, branch;
   logic [1:0] alu_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         opcode_q <= '0;
         wait_cnt <= '0;
         error_q  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_DECODE)
            opcode_q <= bus.Opcode;
         // Any state change clears the counter, so FETCH/MEM always start from zero.
         if (state_next != state)
            wait_cnt <= '0;
         else if ((state == S_FETCH || state == S_MEM) && !bus.Mem_ready)
            wait_cnt <= wait_cnt + 4'd1;
         if (state_next == S_TRAP)
            error_q <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      branch     = 1'b0;
      alu_op     = 2'b00;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            if (bus.Mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end else if (wait_cnt == CNT_LAST) begin
               state_next = S_TRAP;
            end
         end
         S_DECODE: begin
            case (bus.Opcode)
               OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: state_next = S_EXEC;
               default:                                  state_next = S_TRAP;
            endcase
         end
         S_EXEC: begin
            case (opcode_q)
               OP_R: begin
                  alu_op     = 2'b10;
                  state_next = S_WB;
               end
               OP_I: begin
                  alu_op     = 2'b10;
                  alu_src    = 1'b1;
                  state_next = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src    = 1'b1;
                  state_next = S_MEM;
               end
               OP_BRANCH: begin
                  alu_op     = 2'b01;
                  branch     = 1'b1;
                  pc_write   = bus.Zero;
                  pc_src     = bus.Zero;
                  state_next = S_FETCH;
               end
               default: state_next = S_TRAP;
            endcase
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = (opcode_q == OP_LOAD);
            mem_write = (opcode_q == OP_STORE);
            if (bus.Mem_ready)
               state_next = (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
            else if (wait_cnt == CNT_LAST)
               state_next = S_TRAP;
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (opcode_q == OP_LOAD);
            state_next = S_FETCH;
         end
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_TRAP;
      endcase
   end

   // Strobes are gated by reset so they drop the instant reset rises, not at the next edge.
   assign bus.PC_Write   = pc_write   & ~reset;
   assign bus.PC_src     = pc_src     & ~reset;
   assign bus.IR_Write   = ir_write   & ~reset;
   assign bus.I_or_D     = i_or_d     & ~reset;
   assign bus.Mem_Read   = mem_read   & ~reset;
   assign bus.Mem_Write  = mem_write  & ~reset;
   assign bus.Mem_to_Reg = mem_to_reg & ~reset;
   assign bus.Reg_Write  = reg_write  & ~reset;
   assign bus.ALU_src    = alu_src    & ~reset;
   assign bus.Branch     = branch     & ~reset;
   assign bus.ALU_op     = alu_op & {2{~reset}};
   assign bus.State      = state;
   assign bus.Error      = error_q;

endmodule
